iqx4_and_time_axis_stall_detector: RTL and testbench

//  Watches the tvalid/tready pairs of the iqx4_and_time AXIS streams and produces
//  the per-stream axis_block_sigs vector that the deadlock monitor consumes.
//  A stream is blocked once it has stalled for STALL_THRESH consecutive cycles.

---
 rtl/iqx4_and_time_dbg_pkg.sv | 39 +++
 rtl/iqx4_and_time_axis_stall_detector_if.sv | 12 +
 rtl/iqx4_and_time_stall_ctr.sv | 85 ++++++++
 rtl/iqx4_and_time_axis_stall_detector.sv | 82 ++++++++
 tb/tb_iqx4_and_time_axis_stall_detector.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iqx4_and_time_dbg_pkg.sv
// Shared types and helpers for the iqx4_and_time AXIS stall/deadlock debug logic.
// Used by the per-stream stall counters and the detector top level.
package iqx4_and_time_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        BLOCKED = 2'd2
    } stall_state_t;

    localparam int EVT_W       = 16;
    localparam int IDX_W       = 3;
    localparam int MAX_STREAMS = 8;

    // Lowest set bit position; zero when no bit is set.
    function automatic logic [IDX_W-1:0] lowest_set_idx(input logic [MAX_STREAMS-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = MAX_STREAMS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic [EVT_W-1:0] sat_inc_evt(input logic [EVT_W-1:0] val);
        logic [EVT_W-1:0] res;
        if (&val) begin
            res = val;
        end else begin
            res = val + {{(EVT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/iqx4_and_time_axis_stall_detector_if.sv
// tvalid/tready bundle of the iqx4_and_time AXIS streams.
// The detector only ever observes these signals through the monitor modport.
interface iqx4_and_time_axis_stall_detector_if #(
    parameter int N_STREAMS = 3
);
    logic [N_STREAMS-1:0] axis_tvalid;
    logic [N_STREAMS-1:0] axis_tready;

    modport master  (output axis_tvalid, input  axis_tready);
    modport slave   (input  axis_tvalid, output axis_tready);
    modport monitor (input  axis_tvalid, input  axis_tready);
endinterface

// File: rtl/iqx4_and_time_stall_ctr.sv
// One stream's stall detector: stall term, IDLE/COUNT/BLOCKED FSM and saturating
// consecutive-stall counter. onset flags the cycle whose edge enters BLOCKED.
module iqx4_and_time_stall_ctr
    import iqx4_and_time_dbg_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int STALL_THRESH = 16,
    parameter bit IS_OUT       = 1'b0
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic enable,
    input  logic tvalid,
    input  logic tready,
    output logic block,
    output logic onset
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   THRESH_W  = (CNT_W+1)'(STALL_THRESH);
    localparam bit               THRESH_IS_ONE = (STALL_THRESH == 32'sd1);

    stall_state_t     state_r;
    stall_state_t     state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W:0]   cnt_inc_s;
    logic [CNT_W-1:0] cnt_sat_s;
    logic             stall_s;

    // An output stalls on backpressure; an input stalls when the core is starved.
    assign stall_s   = IS_OUT ? (tvalid & ~tready) : (tready & ~tvalid);
    assign cnt_inc_s = {1'b0, cnt_r} + {1'b0, CNT_ONE};
    assign cnt_sat_s = cnt_inc_s[CNT_W] ? CNT_MAX : cnt_inc_s[CNT_W-1:0];

    // Next-state and next-count logic; disable forces the idle state.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (!enable) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = CNT_ZERO;
        end else if (!stall_s) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_nxt_s   = CNT_ONE;
                    state_nxt_s = THRESH_IS_ONE ? BLOCKED : COUNT;
                end
                COUNT: begin
                    cnt_nxt_s   = cnt_sat_s;
                    state_nxt_s = (cnt_inc_s >= THRESH_W) ? BLOCKED : COUNT;
                end
                BLOCKED: begin
                    cnt_nxt_s   = cnt_sat_s;
                    state_nxt_s = BLOCKED;
                end
                default: begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    assign onset = (state_nxt_s == BLOCKED) && (state_r != BLOCKED);

    // State, counter and registered block flag.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            block   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            block   <= (state_nxt_s == BLOCKED);
        end
    end

endmodule

// File: rtl/iqx4_and_time_axis_stall_detector.sv
// Per-stream AXIS stall detector feeding the deadlock monitor, with sticky flags,
// first-blocked stream capture and a saturating block-onset counter for debug.
module iqx4_and_time_axis_stall_detector
    import iqx4_and_time_dbg_pkg::*;
#(
    parameter int                   N_STREAMS    = 3,
    parameter logic [N_STREAMS-1:0] OUT_MASK     = 3'b110,
    parameter int                   CNT_W        = 16,
    parameter int                   STALL_THRESH = 16
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     enable,
    input  logic                     clear_sticky,
    iqx4_and_time_axis_stall_detector_if.monitor axis,
    output logic [N_STREAMS-1:0]     axis_block_sigs,
    output logic [N_STREAMS-1:0]     sticky_block,
    output logic                     first_block_valid,
    output logic [IDX_W-1:0]         first_block_idx,
    output logic [EVT_W-1:0]         block_event_count
);

    logic [N_STREAMS-1:0]   onset_s;
    logic [MAX_STREAMS-1:0] onset_pad_s;
    logic                   any_onset_s;
    logic [IDX_W-1:0]       onset_idx_s;

    for (genvar g = 0; g < N_STREAMS; g++) begin : g_stream
        iqx4_and_time_stall_ctr #(
            .CNT_W        (CNT_W),
            .STALL_THRESH (STALL_THRESH),
            .IS_OUT       (OUT_MASK[g])
        ) u_ctr (
            .ap_clk   (ap_clk),
            .ap_rst_n (ap_rst_n),
            .enable   (enable),
            .tvalid   (axis.axis_tvalid[g]),
            .tready   (axis.axis_tready[g]),
            .block    (axis_block_sigs[g]),
            .onset    (onset_s[g])
        );
    end

    // Widen the onset vector to the priority encoder's fixed width.
    always_comb begin
        onset_pad_s                = {MAX_STREAMS{1'b0}};
        onset_pad_s[N_STREAMS-1:0] = onset_s;
    end

    assign any_onset_s = |onset_s;
    assign onset_idx_s = lowest_set_idx(onset_pad_s);

    // Debug state: a clear and a same-cycle onset resolve in favour of the onset.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            sticky_block      <= {N_STREAMS{1'b0}};
            first_block_valid <= 1'b0;
            first_block_idx   <= {IDX_W{1'b0}};
            block_event_count <= {EVT_W{1'b0}};
        end else if (clear_sticky) begin
            sticky_block      <= onset_s;
            first_block_valid <= any_onset_s;
            first_block_idx   <= any_onset_s ? onset_idx_s : {IDX_W{1'b0}};
            block_event_count <= any_onset_s ? {{(EVT_W-1){1'b0}}, 1'b1} : {EVT_W{1'b0}};
        end else begin
            sticky_block <= sticky_block | onset_s;
            if (any_onset_s && !first_block_valid) begin
                first_block_valid <= 1'b1;
                first_block_idx   <= onset_idx_s;
            end else begin
                first_block_valid <= first_block_valid;
                first_block_idx   <= first_block_idx;
            end
            if (any_onset_s) begin
                block_event_count <= sat_inc_evt(block_event_count);
            end else begin
                block_event_count <= block_event_count;
            end
        end
    end

endmodule

// File: tb/tb_iqx4_and_time_axis_stall_detector.sv
// Self-checking bench: directed scenarios plus randomized traffic compared against
// a run-length reference model of the stall detector.
module tb_iqx4_and_time_axis_stall_detector;

    localparam int         THRESH = 16;
    localparam logic [2:0] MASK   = 3'b110;

    logic        ap_clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic [2:0]  tv;
    logic [2:0]  tr;
    logic [2:0]  axis_block_sigs;
    logic [2:0]  sticky_block;
    logic        first_block_valid;
    logic [2:0]  first_block_idx;
    logic [15:0] block_event_count;

    int n_checks;
    int n_errors;

    // reference model state
    int          run [3];
    logic [2:0]  m_block;
    logic [2:0]  m_sticky;
    logic        m_fv;
    logic [2:0]  m_fidx;
    int          m_cnt;

    iqx4_and_time_axis_stall_detector_if #(.N_STREAMS(3)) bus ();
    assign bus.axis_tvalid = tv;
    assign bus.axis_tready = tr;

    iqx4_and_time_axis_stall_detector #(
        .N_STREAMS    (3),
        .OUT_MASK     (MASK),
        .CNT_W        (16),
        .STALL_THRESH (THRESH)
    ) dut (
        .ap_clk            (ap_clk),
        .ap_rst_n          (rst_n),
        .enable            (en),
        .clear_sticky      (clr),
        .axis              (bus),
        .axis_block_sigs   (axis_block_sigs),
        .sticky_block      (sticky_block),
        .first_block_valid (first_block_valid),
        .first_block_idx   (first_block_idx),
        .block_event_count (block_event_count)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // A stream is blocked once its run of enabled stall cycles reaches THRESH.
    task automatic model_edge();
        logic [2:0] st;
        logic [2:0] on;
        for (int i = 0; i < 3; i++)
            st[i] = MASK[i] ? (tv[i] && !tr[i]) : (tr[i] && !tv[i]);
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) run[i] = 0;
            m_block = 3'b000; m_sticky = 3'b000; m_fv = 1'b0; m_fidx = 3'd0; m_cnt = 0;
        end else begin
            on = 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (en && st[i]) begin
                    if (run[i] < 1000000) run[i] = run[i] + 1;
                end else begin
                    run[i] = 0;
                end
                if (run[i] >= THRESH && !m_block[i]) on[i] = 1'b1;
                m_block[i] = (run[i] >= THRESH);
            end
            if (clr) begin
                m_sticky = 3'b000; m_fv = 1'b0; m_fidx = 3'd0; m_cnt = 0;
            end
            m_sticky = m_sticky | on;
            if (on != 3'b000 && !m_fv) begin
                m_fv = 1'b1;
                for (int i = 2; i >= 0; i--) if (on[i]) m_fidx = 3'(i);
            end
            if (on != 3'b000 && m_cnt < 65535) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        model_edge();
        #1;
    endtask

    task automatic quiesce();
        tv = 3'b000; tr = 3'b000; en = 1'b1; rst_n = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; tv = 3'b111; tr = 3'b000;
        tick();
        tick();
        n_checks++;
        if ({axis_block_sigs, sticky_block, first_block_valid, first_block_idx, block_event_count} !== 26'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got blk=%b stk=%b fv=%b idx=%0d cnt=%0d, want all 0",
                     axis_block_sigs, sticky_block, first_block_valid, first_block_idx, block_event_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_block();
        quiesce();
        tv = 3'b100; tr = 3'b000;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_checks++;
            if (axis_block_sigs !== ((k == 16) ? 3'b100 : 3'b000)) begin
                n_errors++;
                $display("FAIL single_block_c%0d: got %b want %b", k, axis_block_sigs, (k == 16) ? 3'b100 : 3'b000);
            end
        end
        n_checks++;
        if (sticky_block !== 3'b100 || first_block_valid !== 1'b1 || first_block_idx !== 3'd2 || block_event_count !== 16'd1) begin
            n_errors++;
            $display("FAIL single_block_dbg: got stk=%b fv=%b idx=%0d cnt=%0d want 100/1/2/1",
                     sticky_block, first_block_valid, first_block_idx, block_event_count);
        end
        tr = 3'b100;
        tick();
        n_checks++;
        if (axis_block_sigs !== 3'b000 || sticky_block !== 3'b100) begin
            n_errors++;
            $display("FAIL single_block_fall: got blk=%b stk=%b want 000/100", axis_block_sigs, sticky_block);
        end
    endtask

    task automatic test_no_block();
        quiesce();
        tv = 3'b100; tr = 3'b000;
        for (int k = 0; k < 31; k++) begin
            tr = (k == 15) ? 3'b100 : 3'b000;
            tick();
            n_checks++;
            if (axis_block_sigs !== 3'b000) begin
                n_errors++;
                $display("FAIL no_block_c%0d: got %b want 000", k, axis_block_sigs);
            end
        end
        n_checks++;
        if (sticky_block !== 3'b000 || block_event_count !== 16'd0 || first_block_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL no_block_dbg: got stk=%b cnt=%0d fv=%b want 000/0/0", sticky_block, block_event_count, first_block_valid);
        end
    endtask

    task automatic test_dual_onset();
        quiesce();
        tv = 3'b010; tr = 3'b001;
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_checks++;
            if (axis_block_sigs !== ((k == 16) ? 3'b011 : 3'b000)) begin
                n_errors++;
                $display("FAIL dual_c%0d: got %b want %b", k, axis_block_sigs, (k == 16) ? 3'b011 : 3'b000);
            end
        end
        n_checks++;
        if (sticky_block !== 3'b011 || first_block_valid !== 1'b1 || first_block_idx !== 3'd0 || block_event_count !== 16'd1) begin
            n_errors++;
            $display("FAIL dual_dbg: got stk=%b fv=%b idx=%0d cnt=%0d want 011/1/0/1",
                     sticky_block, first_block_valid, first_block_idx, block_event_count);
        end
    endtask

    task automatic test_clear_held();
        tv = 3'b010; tr = 3'b000;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (sticky_block !== 3'b000 || first_block_valid !== 1'b0 || block_event_count !== 16'd0 || axis_block_sigs !== 3'b010) begin
            n_errors++;
            $display("FAIL clear_held: got stk=%b fv=%b cnt=%0d blk=%b want 000/0/0/010",
                     sticky_block, first_block_valid, block_event_count, axis_block_sigs);
        end
    endtask

    task automatic test_enable();
        quiesce();
        tv = 3'b010; tr = 3'b000;
        repeat (16) tick();
        n_checks++;
        if (axis_block_sigs !== 3'b010 || block_event_count !== 16'd1) begin
            n_errors++;
            $display("FAIL enable_pre: got blk=%b cnt=%0d want 010/1", axis_block_sigs, block_event_count);
        end
        en = 1'b0;
        tick();
        en = 1'b1;
        n_checks++;
        if (axis_block_sigs !== 3'b000 || sticky_block !== 3'b010 || block_event_count !== 16'd1) begin
            n_errors++;
            $display("FAIL enable_off: got blk=%b stk=%b cnt=%0d want 000/010/1", axis_block_sigs, sticky_block, block_event_count);
        end
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_checks++;
            if (axis_block_sigs !== ((k == 16) ? 3'b010 : 3'b000)) begin
                n_errors++;
                $display("FAIL enable_back_c%0d: got %b want %b", k, axis_block_sigs, (k == 16) ? 3'b010 : 3'b000);
            end
        end
        n_checks++;
        if (block_event_count !== 16'd2) begin
            n_errors++;
            $display("FAIL enable_count: got %0d want 2", block_event_count);
        end
    endtask

    task automatic test_reset_blocked();
        quiesce();
        tv = 3'b100; tr = 3'b000;
        repeat (16) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({axis_block_sigs, sticky_block, first_block_valid, first_block_idx, block_event_count} !== 26'd0) begin
            n_errors++;
            $display("FAIL reset_blocked: got blk=%b stk=%b fv=%b idx=%0d cnt=%0d want all 0",
                     axis_block_sigs, sticky_block, first_block_valid, first_block_idx, block_event_count);
        end
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_checks++;
            if (axis_block_sigs !== ((k == 16) ? 3'b100 : 3'b000)) begin
                n_errors++;
                $display("FAIL reset_reblock_c%0d: got %b want %b", k, axis_block_sigs, (k == 16) ? 3'b100 : 3'b000);
            end
        end
        n_checks++;
        if (block_event_count !== 16'd1 || first_block_idx !== 3'd2) begin
            n_errors++;
            $display("FAIL reset_reblock_dbg: got cnt=%0d idx=%0d want 1/2", block_event_count, first_block_idx);
        end
    endtask

    task automatic test_clear_onset();
        quiesce();
        tv = 3'b100; tr = 3'b000;
        repeat (16) tick();
        tv = 3'b000; tr = 3'b001;
        repeat (15) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (axis_block_sigs !== 3'b001 || sticky_block !== 3'b001 || first_block_valid !== 1'b1 ||
            first_block_idx !== 3'd0 || block_event_count !== 16'd1) begin
            n_errors++;
            $display("FAIL clear_onset: got blk=%b stk=%b fv=%b idx=%0d cnt=%0d want 001/001/1/0/1",
                     axis_block_sigs, sticky_block, first_block_valid, first_block_idx, block_event_count);
        end
    endtask

    task automatic test_random();
        quiesce();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 19) == 0) begin
                    tv[i] = 1'($urandom_range(0, 1));
                    tr[i] = 1'($urandom_range(0, 1));
                end
            end
            en    = ($urandom_range(0, 49) != 0);
            clr   = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
            n_checks++;
            if (axis_block_sigs !== m_block || sticky_block !== m_sticky || first_block_valid !== m_fv ||
                first_block_idx !== m_fidx || block_event_count !== 16'(m_cnt)) begin
                n_errors++;
                $display("FAIL random_c%0d: got blk=%b stk=%b fv=%b idx=%0d cnt=%0d want blk=%b stk=%b fv=%b idx=%0d cnt=%0d",
                         c, axis_block_sigs, sticky_block, first_block_valid, first_block_idx, block_event_count,
                         m_block, m_sticky, m_fv, m_fidx, m_cnt);
            end
        end
        rst_n = 1'b1; clr = 1'b0; en = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 3; i++) run[i] = 0;
        m_block = 3'b000; m_sticky = 3'b000; m_fv = 1'b0; m_fidx = 3'd0; m_cnt = 0;
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; tv = 3'b000; tr = 3'b000;
        test_reset();
        test_single_block();
        test_no_block();
        test_dual_onset();
        test_clear_held();
        test_enable();
        test_reset_blocked();
        test_clear_onset();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
